// File: rtl/order_msg_stream_parser.sv
// Byte-serial order-entry message parser: validates framed ADD/CANCEL/EXEC/REPLACE
// messages and emits one decoded record per good frame through a single output register.
module order_msg_stream_parser #(
  parameter int ID_W    = 32,
  parameter int PRICE_W = 32,
  parameter int SIZE_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_op,
  output logic [ID_W-1:0]    out_order_id,
  output logic [ID_W-1:0]    out_new_id,
  output logic               out_side,
  output logic [PRICE_W-1:0] out_price,
  output logic [SIZE_W-1:0]  out_size,
  output logic [CNT_W-1:0]   msg_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int IDB     = ID_W / 8;
  localparam int PB      = PRICE_W / 8;
  localparam int SB      = SIZE_W / 8;
  localparam int LEN_ADD = 2 + IDB + PB + SB;
  localparam int LEN_CAN = 1 + IDB;
  localparam int LEN_EXE = 1 + IDB + SB;
  localparam int LEN_REP = 1 + 2 * IDB + PB + SB;
  localparam int BODY_A  = ID_W + 8 + PRICE_W + SIZE_W;
  localparam int BODY_U  = 2 * ID_W + PRICE_W + SIZE_W;
  localparam int BODY_W  = (BODY_A > BODY_U) ? BODY_A : BODY_U;
  localparam int LEN_W   = $clog2(BODY_W / 8 + 2);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_CAN = 2'd1;
  localparam logic [1:0] OP_EXE = 2'd2;
  localparam logic [1:0] OP_REP = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    cnt_reg;
  logic [LEN_W-1:0]    len_reg;
  logic [1:0]          op_reg;
  logic                bad_reg, bad_next;
  logic [BODY_W-9:0]   shift_reg;

  logic                out_valid_reg;
  logic [1:0]          out_op_reg;
  logic [ID_W-1:0]     out_order_id_reg, out_new_id_reg;
  logic                out_side_reg;
  logic [PRICE_W-1:0]  out_price_reg;
  logic [SIZE_W-1:0]   out_size_reg;
  logic [CNT_W-1:0]    msg_cnt_reg, err_cnt_reg;

  logic                accept, final_byte, side_bad, err_ev, load_ev;
  logic                type_ok;
  logic [1:0]          type_op;
  logic [LEN_W-1:0]    type_len;
  logic [BODY_W-1:0]   full;

  logic [ID_W-1:0]     rec_id, rec_new_id;
  logic                rec_side;
  logic [PRICE_W-1:0]  rec_price;
  logic [SIZE_W-1:0]   rec_size;

  // Only the completing byte can stall, and only while the record register is still occupied.
  assign final_byte = (state_reg == S_BODY) && (cnt_reg == len_reg - 1'b1);
  assign in_ready   = !(final_byte && out_valid_reg && !out_ready);
  assign accept     = in_valid && in_ready;
  assign side_bad   = (op_reg == OP_ADD) && (cnt_reg == LEN_W'(1 + IDB))
                      && (in_data != 8'h42) && (in_data != 8'h53);
  assign full       = {shift_reg, in_data};

  always_comb begin
    type_ok  = 1'b1;
    type_op  = OP_ADD;
    type_len = LEN_W'(LEN_ADD);
    case (in_data)
      8'h41:   begin type_op = OP_ADD; type_len = LEN_W'(LEN_ADD); end
      8'h58:   begin type_op = OP_CAN; type_len = LEN_W'(LEN_CAN); end
      8'h45:   begin type_op = OP_EXE; type_len = LEN_W'(LEN_EXE); end
      8'h55:   begin type_op = OP_REP; type_len = LEN_W'(LEN_REP); end
      default: type_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    bad_next   = bad_reg;
    err_ev     = 1'b0;
    load_ev    = 1'b0;
    if (accept) begin
      case (state_reg)
        S_IDLE: begin
          bad_next = 1'b0;
          if (type_ok) begin
            if (in_last) err_ev = 1'b1;
            else         state_next = S_BODY;
          end else begin
            err_ev = 1'b1;
            if (!in_last) state_next = S_DROP;
          end
        end
        S_BODY: begin
          if (in_last)         state_next = S_IDLE;
          else if (final_byte) state_next = S_DROP;
          // A frame already flagged bad is not counted a second time.
          err_ev   = !bad_reg && (side_bad || (in_last != final_byte));
          load_ev  = final_byte && in_last && !bad_reg;
          bad_next = bad_reg || side_bad;
        end
        S_DROP: begin
          if (in_last) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      len_reg   <= '0;
      op_reg    <= OP_ADD;
      bad_reg   <= 1'b0;
      shift_reg <= '0;
    end else begin
      bad_reg <= bad_next;
      if (accept && state_reg == S_IDLE) begin
        cnt_reg <= LEN_W'(1);
        len_reg <= type_len;
        op_reg  <= type_op;
      end else if (accept && state_reg == S_BODY) begin
        cnt_reg   <= cnt_reg + 1'b1;
        shift_reg <= {shift_reg[BODY_W-17:0], in_data};
      end
    end
  end

  // Fields are right-aligned in the byte history; unused fields stay zero.
  always_comb begin
    rec_id     = '0;
    rec_new_id = '0;
    rec_side   = 1'b0;
    rec_price  = '0;
    rec_size   = '0;
    case (op_reg)
      OP_ADD: begin
        rec_size  = full[SIZE_W-1:0];
        rec_price = full[SIZE_W +: PRICE_W];
        rec_side  = (full[SIZE_W+PRICE_W +: 8] == 8'h53);
        rec_id    = full[SIZE_W+PRICE_W+8 +: ID_W];
      end
      OP_CAN: rec_id = full[ID_W-1:0];
      OP_EXE: begin
        rec_size = full[SIZE_W-1:0];
        rec_id   = full[SIZE_W +: ID_W];
      end
      default: begin
        rec_size   = full[SIZE_W-1:0];
        rec_price  = full[SIZE_W +: PRICE_W];
        rec_new_id = full[SIZE_W+PRICE_W +: ID_W];
        rec_id     = full[SIZE_W+PRICE_W+ID_W +: ID_W];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg    <= 1'b0;
      out_op_reg       <= '0;
      out_order_id_reg <= '0;
      out_new_id_reg   <= '0;
      out_side_reg     <= 1'b0;
      out_price_reg    <= '0;
      out_size_reg     <= '0;
      msg_cnt_reg      <= '0;
      err_cnt_reg      <= '0;
    end else begin
      if (load_ev) begin
        out_valid_reg    <= 1'b1;
        out_op_reg       <= op_reg;
        out_order_id_reg <= rec_id;
        out_new_id_reg   <= rec_new_id;
        out_side_reg     <= rec_side;
        out_price_reg    <= rec_price;
        out_size_reg     <= rec_size;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (load_ev && msg_cnt_reg != '1) msg_cnt_reg <= msg_cnt_reg + 1'b1;
      if (err_ev && err_cnt_reg != '1)  err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_op       = out_op_reg;
  assign out_order_id = out_order_id_reg;
  assign out_new_id   = out_new_id_reg;
  assign out_side     = out_side_reg;
  assign out_price    = out_price_reg;
  assign out_size     = out_size_reg;
  assign msg_cnt      = msg_cnt_reg;
  assign err_cnt      = err_cnt_reg;

endmodule
